// File: rtl/despejo_memoria_dados.sv
// despejo_memoria_dados: walks an inclusive address range of the data memory,
// reads each 32-bit word combinationally and streams it MSB byte first over a
// byte-wide valid/ready interface towards the UART transmitter.
// Optional feature: define DESPEJO_CHECKSUM_EN to append one XOR checksum byte
// after the last data byte of the dump.
module despejo_memoria_dados #(
  parameter int LARGURA_END = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [LARGURA_END-1:0] end_inicial,
  input  logic [LARGURA_END-1:0] end_final,
  output logic                   sinal_ler,
  output logic                   sinal_escrever,
  output logic [LARGURA_END-1:0] endereco,
  input  logic [31:0]            dado_ler,
  output logic [7:0]             tx_dado,
  output logic                   tx_valido,
  input  logic                   tx_pronto,
  output logic                   ocupado,
  output logic                   concluido
);

`ifdef DESPEJO_CHECKSUM_EN
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LER      = 3'd1,
    ENVIAR   = 3'd2,
    CHECKSUM = 3'd3,
    FIM      = 3'd4
  } estado_t;
`else
  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    LER    = 3'd1,
    ENVIAR = 3'd2,
    FIM    = 3'd4
  } estado_t;
`endif

  localparam logic [LARGURA_END-1:0] UM_END = LARGURA_END'(1);

  estado_t                state_q, state_d;
  logic [LARGURA_END-1:0] endereco_q, endereco_d;
  logic [LARGURA_END-1:0] end_final_q, end_final_d;
  logic [31:0]            shift_q, shift_d;
  logic [1:0]             idx_q, idx_d;
  logic                   sinal_ler_q, sinal_ler_d;
  logic                   tx_valido_q, tx_valido_d;
  logic [7:0]             tx_dado_q, tx_dado_d;
  logic                   ocupado_q, ocupado_d;
  logic                   concluido_q, concluido_d;
  logic                   transfer_s;
`ifdef DESPEJO_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  // A byte leaves only when the presented byte is valid and the UART takes it.
  assign transfer_s = tx_valido_q & tx_pronto;

  // Next-state logic; output flops are loaded from the next state so every
  // output is a plain register with no path from tx_pronto.
  always_comb begin
    state_d     = state_q;
    endereco_d  = endereco_q;
    end_final_d = end_final_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
`ifdef DESPEJO_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          state_d     = LER;
          endereco_d  = end_inicial;
          end_final_d = end_final;
          idx_d       = 2'd0;
`ifdef DESPEJO_CHECKSUM_EN
          csum_d      = 8'h00;
`endif
        end else begin
          state_d = OCIOSO;
        end
      end
      LER: begin
        // Memory read is combinational: capture the word in this single cycle.
        shift_d = dado_ler;
        state_d = ENVIAR;
      end
      ENVIAR: begin
        if (transfer_s) begin
          shift_d = {shift_q[23:0], 8'h00};
          idx_d   = idx_q + 2'd1;
`ifdef DESPEJO_CHECKSUM_EN
          csum_d  = csum_q ^ shift_q[31:24];
`endif
          if (idx_q == 2'd3) begin
            if (endereco_q == end_final_q) begin
`ifdef DESPEJO_CHECKSUM_EN
              state_d = CHECKSUM;
`else
              state_d = FIM;
`endif
            end else begin
              // Wraps naturally modulo 2^LARGURA_END.
              endereco_d = endereco_q + UM_END;
              state_d    = LER;
            end
          end else begin
            state_d = ENVIAR;
          end
        end else begin
          state_d = ENVIAR;
        end
      end
`ifdef DESPEJO_CHECKSUM_EN
      CHECKSUM: begin
        if (transfer_s) begin
          state_d = FIM;
        end else begin
          state_d = CHECKSUM;
        end
      end
`endif
      FIM: begin
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase

    sinal_ler_d = (state_d == LER);
    concluido_d = (state_d == FIM);
`ifdef DESPEJO_CHECKSUM_EN
    tx_valido_d = (state_d == ENVIAR) || (state_d == CHECKSUM);
    if (state_d == ENVIAR) begin
      tx_dado_d = shift_d[31:24];
    end else if (state_d == CHECKSUM) begin
      tx_dado_d = csum_d;
    end else begin
      tx_dado_d = 8'h00;
    end
`else
    tx_valido_d = (state_d == ENVIAR);
    if (state_d == ENVIAR) begin
      tx_dado_d = shift_d[31:24];
    end else begin
      tx_dado_d = 8'h00;
    end
`endif
    ocupado_d = (state_d == LER) || tx_valido_d;
  end

  // State, datapath and output registers; reset aborts any dump in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      endereco_q  <= '0;
      end_final_q <= '0;
      shift_q     <= 32'h0000_0000;
      idx_q       <= 2'd0;
      sinal_ler_q <= 1'b0;
      tx_valido_q <= 1'b0;
      tx_dado_q   <= 8'h00;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
`ifdef DESPEJO_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      endereco_q  <= endereco_d;
      end_final_q <= end_final_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      sinal_ler_q <= sinal_ler_d;
      tx_valido_q <= tx_valido_d;
      tx_dado_q   <= tx_dado_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
`ifdef DESPEJO_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign sinal_ler      = sinal_ler_q;
  assign sinal_escrever = 1'b0;
  assign endereco       = endereco_q;
  assign tx_dado        = tx_dado_q;
  assign tx_valido      = tx_valido_q;
  assign ocupado        = ocupado_q;
  assign concluido      = concluido_q;

endmodule

// File: tb/tb_despejo_memoria_dados.sv
// Directed bench for despejo_memoria_dados with a behavioural 128x32 memory.
module tb_despejo_memoria_dados;

`ifdef DESPEJO_CHECKSUM_EN
  localparam int CS_EN = 1;
`else
  localparam int CS_EN = 0;
`endif

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic [6:0]  end_inicial;
  logic [6:0]  end_final;
  logic        sinal_ler;
  logic        sinal_escrever;
  logic [6:0]  endereco;
  logic [31:0] dado_ler;
  logic [7:0]  tx_dado;
  logic        tx_valido;
  logic        tx_pronto;
  logic        ocupado;
  logic        concluido;

  logic [31:0] mem [0:127];
  logic [7:0]  exp_bytes [0:7];
  logic [6:0]  exp_addr [0:1];

  int n_assert;
  int n_fail;

  despejo_memoria_dados #(.LARGURA_END(7)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .end_inicial(end_inicial), .end_final(end_final),
    .sinal_ler(sinal_ler), .sinal_escrever(sinal_escrever),
    .endereco(endereco), .dado_ler(dado_ler),
    .tx_dado(tx_dado), .tx_valido(tx_valido), .tx_pronto(tx_pronto),
    .ocupado(ocupado), .concluido(concluido)
  );

  // Combinational read port of the data memory.
  assign dado_ler = mem[endereco];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic [6:0] a, input logic [6:0] b);
    @(negedge clock);
    iniciar     = 1'b1;
    end_inicial = a;
    end_final   = b;
    @(posedge clock);
    #1 iniciar = 1'b0;
  endtask

  // Cycle-by-cycle check of a dump with tx_pronto held high; cycle 1 is LER.
  task automatic run_and_check(input int nw);
    logic [7:0] cs;
    int w, pos, total;
    logic e_ler, e_env, e_cs, e_fim;
    cs = 8'h00;
    for (int i = 0; i < 4 * nw; i++) cs = cs ^ exp_bytes[i];
    total = 5 * nw + 1 + CS_EN + 1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clock);
      w     = (c - 1) / 5;
      pos   = (c - 1) % 5;
      e_ler = (c <= 5 * nw) && (pos == 0);
      e_env = (c <= 5 * nw) && (pos != 0);
      e_cs  = (CS_EN == 1) && (c == 5 * nw + 1);
      e_fim = (c == 5 * nw + 1 + CS_EN);
      chk($sformatf("c%0d sinal_ler", c), 32'(sinal_ler), 32'(e_ler));
      chk($sformatf("c%0d tx_valido", c), 32'(tx_valido), 32'(e_env | e_cs));
      chk($sformatf("c%0d ocupado", c), 32'(ocupado), 32'(e_ler | e_env | e_cs));
      chk($sformatf("c%0d concluido", c), 32'(concluido), 32'(e_fim));
      chk($sformatf("c%0d sinal_escrever", c), 32'(sinal_escrever), 32'd0);
      if (e_env) chk($sformatf("c%0d tx_dado", c), 32'(tx_dado), 32'(exp_bytes[w * 4 + pos - 1]));
      if (e_cs)  chk($sformatf("c%0d checksum", c), 32'(tx_dado), 32'(cs));
      if (c <= 5 * nw) chk($sformatf("c%0d endereco", c), 32'(endereco), 32'(exp_addr[w]));
      else             chk($sformatf("c%0d endereco hold", c), 32'(endereco), 32'(exp_addr[nw - 1]));
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    iniciar     = 1'b0;
    end_inicial = 7'd0;
    end_final   = 7'd0;
    tx_pronto   = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0000;

    // Reset state
    #3;
    chk("rst sinal_ler", 32'(sinal_ler), 32'd0);
    chk("rst tx_valido", 32'(tx_valido), 32'd0);
    chk("rst tx_dado", 32'(tx_dado), 32'd0);
    chk("rst endereco", 32'(endereco), 32'd0);
    chk("rst ocupado", 32'(ocupado), 32'd0);
    chk("rst concluido", 32'(concluido), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Two-word dump 3..4
    mem[3] = 32'h11223344;
    mem[4] = 32'hAABBCCDD;
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    exp_bytes[4] = 8'hAA; exp_bytes[5] = 8'hBB; exp_bytes[6] = 8'hCC; exp_bytes[7] = 8'hDD;
    exp_addr[0] = 7'd3; exp_addr[1] = 7'd4;
    start(7'd3, 7'd4);
    run_and_check(2);

    // Wrapping dump 127..0
    mem[127] = 32'hDEADBEEF;
    mem[0]   = 32'h01020304;
    exp_bytes[0] = 8'hDE; exp_bytes[1] = 8'hAD; exp_bytes[2] = 8'hBE; exp_bytes[3] = 8'hEF;
    exp_bytes[4] = 8'h01; exp_bytes[5] = 8'h02; exp_bytes[6] = 8'h03; exp_bytes[7] = 8'h04;
    exp_addr[0] = 7'd127; exp_addr[1] = 7'd0;
    start(7'd127, 7'd0);
    run_and_check(2);

    // Single word 5..5 with a 3-cycle stall on the 2nd byte and an ignored start
    mem[5] = 32'hCAFEF00D;
    start(7'd5, 7'd5);
    @(negedge clock);
    chk("stall c1 sinal_ler", 32'(sinal_ler), 32'd1);
    chk("stall c1 endereco", 32'(endereco), 32'd5);
    @(negedge clock);
    chk("stall c2 tx_dado", 32'(tx_dado), 32'hCA);
    @(posedge clock);
    #1;
    tx_pronto   = 1'b0;
    iniciar     = 1'b1;
    end_inicial = 7'd60;
    end_final   = 7'd61;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("stall%0d tx_dado", k), 32'(tx_dado), 32'hFE);
      chk($sformatf("stall%0d tx_valido", k), 32'(tx_valido), 32'd1);
      chk($sformatf("stall%0d ocupado", k), 32'(ocupado), 32'd1);
      chk($sformatf("stall%0d endereco", k), 32'(endereco), 32'd5);
    end
    @(posedge clock);
    #1;
    tx_pronto = 1'b1;
    iniciar   = 1'b0;
    @(negedge clock);
    chk("stall c6 tx_dado", 32'(tx_dado), 32'hFE);
    @(negedge clock);
    chk("stall c7 tx_dado", 32'(tx_dado), 32'hF0);
    @(negedge clock);
    chk("stall c8 tx_dado", 32'(tx_dado), 32'h0D);
    chk("stall c8 concluido", 32'(concluido), 32'd0);
`ifdef DESPEJO_CHECKSUM_EN
    @(negedge clock);
    chk("stall c9 checksum", 32'(tx_dado), 32'hC9);
    chk("stall c9 concluido", 32'(concluido), 32'd0);
`endif
    @(negedge clock);
    chk("stall fim concluido", 32'(concluido), 32'd1);
    chk("stall fim tx_valido", 32'(tx_valido), 32'd0);
    @(negedge clock);
    chk("stall after ocupado", 32'(ocupado), 32'd0);
    chk("stall after concluido", 32'(concluido), 32'd0);
    chk("stall after endereco", 32'(endereco), 32'd5);

    // Asynchronous reset in the middle of a byte
    mem[20] = 32'h55667788;
    mem[21] = 32'h99AABBCC;
    start(7'd20, 7'd21);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("pre-rst tx_dado", 32'(tx_dado), 32'h66);
    #2 reset = 1'b1;
    #1;
    chk("arst sinal_ler", 32'(sinal_ler), 32'd0);
    chk("arst tx_valido", 32'(tx_valido), 32'd0);
    chk("arst tx_dado", 32'(tx_dado), 32'd0);
    chk("arst endereco", 32'(endereco), 32'd0);
    chk("arst ocupado", 32'(ocupado), 32'd0);
    chk("arst concluido", 32'(concluido), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk($sformatf("post-rst%0d concluido", k), 32'(concluido), 32'd0);
      chk($sformatf("post-rst%0d ocupado", k), 32'(ocupado), 32'd0);
    end

    // Fresh start after the abort
    mem[9] = 32'h0BADC0DE;
    exp_bytes[0] = 8'h0B; exp_bytes[1] = 8'hAD; exp_bytes[2] = 8'hC0; exp_bytes[3] = 8'hDE;
    exp_addr[0] = 7'd9;
    start(7'd9, 7'd9);
    run_and_check(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
